// File: rtl/pad_data_monitor_if.sv
// Pad word bus from the link aligner: {BCID, hit bitmap} qualified by a one-cycle valid strobe.
interface pad_data_monitor_if #(
    parameter int HIT_W  = 104,
    parameter int BCID_W = 12
);
    logic [HIT_W+BCID_W-1:0] pad_data_in;
    logic                    pad_data_valid;

    modport master (output pad_data_in, output pad_data_valid);
    modport slave  (input  pad_data_in, input  pad_data_valid);
endinterface

// File: rtl/pad_data_monitor.sv
// Pad-mode data monitor: decodes the aligner status word, counts link breaks/valid/hit words
// and checks BCID continuity, capturing the first mismatch for debug.
module pad_data_monitor #(
    parameter int HIT_W    = 104,
    parameter int BCID_W   = 12,
    parameter int BCID_MAX = 3563,
    parameter int CNT_W    = 16
) (
    input  logic                  clk160,
    input  logic                  reset_n,
    pad_data_monitor_if.slave     pad,
    input  logic [18:0]           link_message,
    input  logic                  clear_counters,
    output logic                  linked,
    output logic [3:0]            state,
    output logic [9:0]            syn_cnt,
    output logic [4:0]            err_cnt,
    output logic [1:0]            mon_state,
    output logic                  hit_flag,
    output logic [BCID_W-1:0]     bcid,
    output logic [CNT_W-1:0]      link_break_cnt,
    output logic [CNT_W-1:0]      valid_cnt,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      bcid_err_cnt,
    output logic                  bcid_err_sticky,
    output logic [BCID_W-1:0]     first_err_exp,
    output logic [BCID_W-1:0]     first_err_got
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_CHECK = 2'd2
    } mon_state_e;

    localparam logic [BCID_W-1:0] BCID_LAST = BCID_W'(BCID_MAX);

    function automatic logic [BCID_W-1:0] bcid_next(input logic [BCID_W-1:0] b);
        return (b >= BCID_LAST) ? '0 : b + BCID_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    mon_state_e          mon_state_q, mon_state_d;
    logic                linked_q, linked_d;
    logic [3:0]          state_q, state_d;
    logic [9:0]          syn_cnt_q, syn_cnt_d;
    logic [4:0]          err_cnt_q, err_cnt_d;
    logic                hit_flag_q, hit_flag_d;
    logic [BCID_W-1:0]   bcid_q, bcid_d;
    logic [BCID_W-1:0]   exp_bcid_q, exp_bcid_d;
    logic [CNT_W-1:0]    link_break_cnt_q, link_break_cnt_d;
    logic [CNT_W-1:0]    valid_cnt_q, valid_cnt_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    bcid_err_cnt_q, bcid_err_cnt_d;
    logic                sticky_q, sticky_d;
    logic [BCID_W-1:0]   first_err_exp_q, first_err_exp_d;
    logic [BCID_W-1:0]   first_err_got_q, first_err_got_d;
    logic                clr_in_q, clr_in_d;
    logic                clr_dly_q, clr_dly_d;

    logic                link_in;
    logic                link_break;
    logic                clr_pulse;
    logic                hit_any;
    logic [BCID_W-1:0]   bcid_in;

    always_comb begin
        link_in    = link_message[14];
        link_break = linked_q & ~link_in;
        clr_pulse  = clr_in_q & ~clr_dly_q;
        bcid_in    = pad.pad_data_in[HIT_W +: BCID_W];
        hit_any    = |pad.pad_data_in[HIT_W-1:0];

        mon_state_d      = mon_state_q;
        linked_d         = link_in;
        state_d          = link_message[18:15];
        syn_cnt_d        = {1'b0, link_message[13:5]};
        err_cnt_d        = link_message[4:0];
        hit_flag_d       = hit_flag_q;
        bcid_d           = bcid_q;
        exp_bcid_d       = exp_bcid_q;
        link_break_cnt_d = link_break_cnt_q;
        valid_cnt_d      = valid_cnt_q;
        hit_cnt_d        = hit_cnt_q;
        bcid_err_cnt_d   = bcid_err_cnt_q;
        sticky_d         = sticky_q;
        first_err_exp_d  = first_err_exp_q;
        first_err_got_d  = first_err_got_q;
        clr_in_d         = clear_counters;
        clr_dly_d        = clr_in_q;

        if (pad.pad_data_valid) begin
            valid_cnt_d = sat_inc(valid_cnt_q);
            bcid_d      = bcid_in;
            hit_flag_d  = hit_any;
            if (hit_any) hit_cnt_d = sat_inc(hit_cnt_q);
        end

        if (link_break) link_break_cnt_d = sat_inc(link_break_cnt_q);

        // A word arriving with the link drop is counted above but never checked.
        if (!link_in) begin
            mon_state_d = ST_IDLE;
        end else begin
            unique case (mon_state_q)
                ST_IDLE: mon_state_d = ST_ARM;
                ST_ARM: begin
                    if (pad.pad_data_valid) begin
                        exp_bcid_d  = bcid_next(bcid_in);
                        mon_state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (pad.pad_data_valid) begin
                        if (bcid_in != exp_bcid_q) begin
                            bcid_err_cnt_d = sat_inc(bcid_err_cnt_q);
                            if (!sticky_q) begin
                                sticky_d        = 1'b1;
                                first_err_exp_d = exp_bcid_q;
                                first_err_got_d = bcid_in;
                            end
                        end
                        // Resynchronise on what was received so one slip costs one error.
                        exp_bcid_d = bcid_next(bcid_in);
                    end
                end
                default: mon_state_d = ST_IDLE;
            endcase
        end

        if (clr_pulse) begin
            link_break_cnt_d = '0;
            valid_cnt_d      = '0;
            hit_cnt_d        = '0;
            bcid_err_cnt_d   = '0;
            sticky_d         = 1'b0;
            first_err_exp_d  = '0;
            first_err_got_d  = '0;
        end
    end

    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            mon_state_q      <= ST_IDLE;
            linked_q         <= 1'b0;
            state_q          <= '0;
            syn_cnt_q        <= '0;
            err_cnt_q        <= '0;
            hit_flag_q       <= 1'b0;
            bcid_q           <= '0;
            exp_bcid_q       <= '0;
            link_break_cnt_q <= '0;
            valid_cnt_q      <= '0;
            hit_cnt_q        <= '0;
            bcid_err_cnt_q   <= '0;
            sticky_q         <= 1'b0;
            first_err_exp_q  <= '0;
            first_err_got_q  <= '0;
            clr_in_q         <= 1'b0;
            clr_dly_q        <= 1'b0;
        end else begin
            mon_state_q      <= mon_state_d;
            linked_q         <= linked_d;
            state_q          <= state_d;
            syn_cnt_q        <= syn_cnt_d;
            err_cnt_q        <= err_cnt_d;
            hit_flag_q       <= hit_flag_d;
            bcid_q           <= bcid_d;
            exp_bcid_q       <= exp_bcid_d;
            link_break_cnt_q <= link_break_cnt_d;
            valid_cnt_q      <= valid_cnt_d;
            hit_cnt_q        <= hit_cnt_d;
            bcid_err_cnt_q   <= bcid_err_cnt_d;
            sticky_q         <= sticky_d;
            first_err_exp_q  <= first_err_exp_d;
            first_err_got_q  <= first_err_got_d;
            clr_in_q         <= clr_in_d;
            clr_dly_q        <= clr_dly_d;
        end
    end

    assign linked          = linked_q;
    assign state           = state_q;
    assign syn_cnt         = syn_cnt_q;
    assign err_cnt         = err_cnt_q;
    assign mon_state       = mon_state_q;
    assign hit_flag        = hit_flag_q;
    assign bcid            = bcid_q;
    assign link_break_cnt  = link_break_cnt_q;
    assign valid_cnt       = valid_cnt_q;
    assign hit_cnt         = hit_cnt_q;
    assign bcid_err_cnt    = bcid_err_cnt_q;
    assign bcid_err_sticky = sticky_q;
    assign first_err_exp   = first_err_exp_q;
    assign first_err_got   = first_err_got_q;

endmodule

// File: tb/tb_pad_data_monitor.sv
// Bench for pad_data_monitor: directed scenarios plus random traffic against a behavioural model,
// driving a 16-bit-counter instance and a 4-bit-counter instance from the same stimulus.
`timescale 1ns/1ps
module tb_pad_data_monitor;
    localparam int HW = 104;
    localparam int BW = 12;
    localparam int BMAX = 3563;

    logic clk160 = 1'b0;
    logic reset_n = 1'b0;
    logic [18:0] link_message = '0;
    logic clear_counters = 1'b0;

    always #3 clk160 = ~clk160;

    pad_data_monitor_if #(.HIT_W(HW), .BCID_W(BW)) pad_if ();

    logic        a_linked, b_linked;
    logic [3:0]  a_state, b_state;
    logic [9:0]  a_syn, b_syn;
    logic [4:0]  a_errf, b_errf;
    logic [1:0]  a_mon, b_mon;
    logic        a_hitf, b_hitf;
    logic [BW-1:0] a_bcid, b_bcid, a_fexp, b_fexp, a_fgot, b_fgot;
    logic [15:0] a_brk, a_vld, a_hit, a_err;
    logic [3:0]  b_brk, b_vld, b_hit, b_err;
    logic        a_sticky, b_sticky;

    pad_data_monitor #(.HIT_W(HW), .BCID_W(BW), .BCID_MAX(BMAX), .CNT_W(16)) u_dut (
        .clk160(clk160), .reset_n(reset_n), .pad(pad_if), .link_message(link_message),
        .clear_counters(clear_counters), .linked(a_linked), .state(a_state), .syn_cnt(a_syn),
        .err_cnt(a_errf), .mon_state(a_mon), .hit_flag(a_hitf), .bcid(a_bcid),
        .link_break_cnt(a_brk), .valid_cnt(a_vld), .hit_cnt(a_hit), .bcid_err_cnt(a_err),
        .bcid_err_sticky(a_sticky), .first_err_exp(a_fexp), .first_err_got(a_fgot));

    pad_data_monitor #(.HIT_W(HW), .BCID_W(BW), .BCID_MAX(BMAX), .CNT_W(4)) u_sat (
        .clk160(clk160), .reset_n(reset_n), .pad(pad_if), .link_message(link_message),
        .clear_counters(clear_counters), .linked(b_linked), .state(b_state), .syn_cnt(b_syn),
        .err_cnt(b_errf), .mon_state(b_mon), .hit_flag(b_hitf), .bcid(b_bcid),
        .link_break_cnt(b_brk), .valid_cnt(b_vld), .hit_cnt(b_hit), .bcid_err_cnt(b_err),
        .bcid_err_sticky(b_sticky), .first_err_exp(b_fexp), .first_err_got(b_fgot));

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=0x%0h exp=0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: true event counts since the last clear; saturation is applied on compare.
    int m_valid, m_hit, m_break, m_err, m_bcid, m_exp, m_fexp, m_fgot, m_mode;
    bit m_sticky, m_hitflag, m_linked;
    int m_state4, m_syn, m_errf;
    bit clr_prev1, clr_prev2;

    function automatic int nxt(input int b);
        return (b >= BMAX) ? 0 : b + 1;
    endfunction

    function automatic int sat(input int v, input int w);
        int lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_hit = 0; m_break = 0; m_err = 0; m_bcid = 0; m_exp = 0;
        m_fexp = 0; m_fgot = 0; m_mode = 0; m_sticky = 0; m_hitflag = 0; m_linked = 0;
        m_state4 = 0; m_syn = 0; m_errf = 0; clr_prev1 = 0; clr_prev2 = 0;
    endtask

    task automatic model_step(input int b, input bit hits_any, input bit vld,
                              input logic [18:0] lm, input bit clr);
        bit lk = lm[14];
        bit clear_now = clr_prev1 && !clr_prev2;
        if (vld) begin
            m_valid++;
            m_bcid = b;
            m_hitflag = hits_any;
            if (hits_any) m_hit++;
        end
        if (m_linked && !lk) m_break++;
        if (!lk) m_mode = 0;
        else if (m_mode == 0) m_mode = 1;
        else if (vld) begin
            if (m_mode == 2 && b != m_exp) begin
                m_err++;
                if (!m_sticky) begin
                    m_sticky = 1; m_fexp = m_exp; m_fgot = b;
                end
            end
            m_exp = nxt(b);
            m_mode = 2;
        end
        if (clear_now) begin
            m_valid = 0; m_hit = 0; m_break = 0; m_err = 0;
            m_sticky = 0; m_fexp = 0; m_fgot = 0;
        end
        m_linked = lk;
        m_state4 = int'(lm[18:15]);
        m_syn = int'(lm[13:5]);
        m_errf = int'(lm[4:0]);
        clr_prev2 = clr_prev1;
        clr_prev1 = clr;
    endtask

    task automatic check_all();
        check_val("linked", a_linked, m_linked);
        check_val("state", a_state, m_state4);
        check_val("syn_cnt", a_syn, m_syn);
        check_val("err_cnt", a_errf, m_errf);
        check_val("mon_state", a_mon, m_mode);
        check_val("hit_flag", a_hitf, m_hitflag);
        check_val("bcid", a_bcid, m_bcid);
        check_val("link_break_cnt", a_brk, sat(m_break, 16));
        check_val("valid_cnt", a_vld, sat(m_valid, 16));
        check_val("hit_cnt", a_hit, sat(m_hit, 16));
        check_val("bcid_err_cnt", a_err, sat(m_err, 16));
        check_val("sticky", a_sticky, m_sticky);
        check_val("first_err_exp", a_fexp, m_fexp);
        check_val("first_err_got", a_fgot, m_fgot);
        check_val("sat4_valid_cnt", b_vld, sat(m_valid, 4));
        check_val("sat4_hit_cnt", b_hit, sat(m_hit, 4));
        check_val("sat4_break_cnt", b_brk, sat(m_break, 4));
        check_val("sat4_err_cnt", b_err, sat(m_err, 4));
    endtask

    // One clock of stimulus: drive, let the edge happen, advance the model, compare 1 ns later.
    task automatic cycle(input int b, input logic [HW-1:0] hits, input bit vld,
                         input logic [18:0] lm, input bit clr);
        pad_if.pad_data_in    = {BW'(b), hits};
        pad_if.pad_data_valid = vld;
        link_message          = lm;
        clear_counters        = clr;
        @(posedge clk160);
        model_step(b, |hits, vld, lm, clr);
        #1;
        if (vld)
            $display("txn t=%0t bcid=%0d hit=%0b link=%0b clr=%0b -> valid_cnt=%0d err_cnt=%0d mon=%0d",
                     $time, b, |hits, lm[14], clr, a_vld, a_err, a_mon);
        check_all();
    endtask

    localparam logic [18:0] LM_UP = 19'h04000;
    localparam logic [18:0] LM_DN = 19'h00000;
    localparam logic [HW-1:0] NO_HIT = '0;
    localparam logic [HW-1:0] HIT0 = HW'(1);

    initial begin
        logic [HW-1:0] hv;
        int seq_a[4];
        int seq_b[4];
        seq_a = '{3562, 3563, 0, 1};
        seq_b = '{5, 7, 8, 9};
        model_reset();
        pad_if.pad_data_in = '0;
        pad_if.pad_data_valid = 1'b0;
        repeat (3) @(posedge clk160);
        #1;
        check_all();
        check_val("reset_mon_state", a_mon, 0);
        reset_n = 1'b1;

        // Link up, ten words BCID 100..109, only word 3 carries a hit.
        cycle(0, NO_HIT, 0, LM_UP, 0);
        check_val("arm_after_link", a_mon, 1);
        for (int i = 0; i < 10; i++) cycle(100 + i, (i == 3) ? HIT0 : NO_HIT, 1, LM_UP, 0);
        check_val("basic_valid_cnt", a_vld, 10);
        check_val("basic_hit_cnt", a_hit, 1);
        check_val("basic_err_cnt", a_err, 0);
        check_val("basic_mon_check", a_mon, 2);
        check_val("basic_bcid", a_bcid, 109);

        // Re-seed, then the orbit wrap sequence.
        cycle(0, NO_HIT, 0, LM_DN, 0);
        cycle(0, NO_HIT, 0, LM_UP, 0);
        for (int i = 0; i < 4; i++) cycle(seq_a[i], NO_HIT, 1, LM_UP, 0);
        check_val("wrap_err_cnt", a_err, 0);

        // Re-seed on 5, then a one-BCID skip.
        cycle(0, NO_HIT, 0, LM_DN, 0);
        cycle(0, NO_HIT, 0, LM_UP, 0);
        for (int i = 0; i < 4; i++) cycle(seq_b[i], NO_HIT, 1, LM_UP, 0);
        check_val("skip_err_cnt", a_err, 1);
        check_val("skip_sticky", a_sticky, 1);
        check_val("skip_first_exp", a_fexp, 6);
        check_val("skip_first_got", a_fgot, 7);

        // Clear: held high three cycles, takes effect two edges after the rising edge.
        for (int i = 0; i < 3; i++) cycle(0, NO_HIT, 0, LM_UP, 1);
        cycle(0, NO_HIT, 0, LM_UP, 0);
        check_val("clear_break_cnt", a_brk, 0);
        check_val("clear_sticky", a_sticky, 0);

        // Three link drops, then a BCID jump after relink must only seed.
        for (int k = 0; k < 3; k++) begin
            cycle(0, NO_HIT, 0, LM_DN, 0);
            check_val("drop_mon_idle", a_mon, 0);
            cycle(0, NO_HIT, 0, LM_UP, 0);
            cycle(0, NO_HIT, 0, LM_UP, 0);
        end
        check_val("drop_break_cnt", a_brk, 3);
        cycle(2000, NO_HIT, 1, LM_UP, 0);
        cycle(2001, NO_HIT, 1, LM_UP, 0);
        check_val("relink_err_cnt", a_err, 0);

        // Clear edge coinciding with valid words.
        cycle(2002, HIT0, 1, LM_UP, 1);
        cycle(2003, HIT0, 1, LM_UP, 1);
        check_val("simul_valid_cnt", a_vld, 0);
        check_val("simul_hit_cnt", a_hit, 0);
        check_val("simul_break_cnt", a_brk, 0);
        cycle(0, NO_HIT, 0, LM_UP, 0);

        // Valid word with the link drop: counted, not checked.
        hv = '0; hv[5] = 1'b1;
        cycle(3000, hv, 1, LM_DN, 0);
        check_val("dropword_valid_cnt", a_vld, 1);
        check_val("dropword_hit_cnt", a_hit, 1);
        check_val("dropword_err_cnt", a_err, 0);
        check_val("dropword_mon", a_mon, 0);

        // Saturation of the 4-bit instance.
        cycle(0, NO_HIT, 0, LM_UP, 0);
        for (int i = 0; i < 20; i++) cycle(10 + i, HIT0, 1, LM_UP, 0);
        check_val("sat_valid_cnt", b_vld, 15);
        check_val("sat_hit_cnt", b_hit, 15);
        check_val("nosat_valid_cnt", a_vld, 21);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            int r, b;
            bit vld, lk, clr;
            logic [18:0] lm;
            r = int'($urandom_range(0, 19));
            if (r == 0) b = int'($urandom_range(0, 4095));
            else if (r == 1) b = 3562 + int'($urandom_range(0, 1));
            else b = nxt(m_bcid);
            vld = ($urandom_range(0, 9) < 6);
            lk  = ($urandom_range(0, 19) != 0);
            clr = ($urandom_range(0, 15) == 0);
            hv = '0;
            if ($urandom_range(0, 3) == 0) hv[$urandom_range(0, HW - 1)] = 1'b1;
            lm = {4'($urandom), lk, 9'($urandom), 5'($urandom)};
            cycle(b, hv, vld, lm, clr);
        end

        // Field decode.
        cycle(0, NO_HIT, 0, 19'h7FFFF, 0);
        check_val("dec_state", a_state, 15);
        check_val("dec_linked", a_linked, 1);
        check_val("dec_syn_cnt", a_syn, 10'h1FF);
        check_val("dec_err_cnt", a_errf, 5'h1F);

        // Asynchronous reset mid-cycle: outputs must drop before the next edge.
        cycle(500, HIT0, 1, LM_UP, 0);
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check_val("async_rst_valid_cnt", a_vld, 0);
        check_val("async_rst_mon", a_mon, 0);
        @(negedge clk160);
        reset_n = 1'b1;
        cycle(0, NO_HIT, 0, LM_UP, 0);
        cycle(1234, NO_HIT, 1, LM_UP, 0);
        cycle(77, NO_HIT, 1, LM_UP, 0);
        check_val("post_rst_err_cnt", a_err, 1);
        check_val("post_rst_first_exp", a_fexp, 1235);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
